// File: rtl/dma_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dma_fifo_ctrl
//   Single-channel DMA sequencer. Copies cfg_len 32-bit words from a source
//   address range to a destination address range. Words are staged through an
//   external 16-deep synchronous FIFO in bursts of up to BURST_LEN words:
//   a burst is read on the req/ack read port and pushed into the FIFO, then
//   popped word by word and written on the req/ack write port.
//
//   Optional feature (compile-time macro DMA_CTRL_ABORT_EN):
//     adds input 'abort' and output 'aborted'. An abort in READ/WRITE lets
//     the outstanding request finish on its ack, then ends the transfer in
//     DONE; an abort in POP/LOAD ends it on the next cycle. Staged FIFO words
//     are discarded (the next start flushes the FIFO).
//
// Ports
//   clk, rst_n             clock (posedge), asynchronous active-low reset
//   start                  one-cycle request, accepted only in IDLE
//   cfg_src/cfg_dst/cfg_len  transfer setup, latched on accepted start
//   busy, done, err        status: not-IDLE, one-cycle completion, sticky
//                          FIFO-flag consistency error
//   rd_req/rd_addr/rd_ack/rd_data   word read port
//   wr_req/wr_addr/wr_data/wr_ack   word write port
//   fifo_clr, fifo_wr_en, fifo_din, fifo_full,
//   fifo_rd_en, fifo_dout, fifo_empty   FIFO control/data
//   abort, aborted         only with DMA_CTRL_ABORT_EN
// ---------------------------------------------------------------------------
module dma_fifo_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef DMA_CTRL_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              fifo_clr,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty
);

  localparam int BC_W = $clog2(BURST_LEN) + 1;
  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH) begin : g_bad_burst_len
    $error("dma_fifo_ctrl: BURST_LEN must be in 1..FIFO_DEPTH");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_POP   = 3'd2,
    S_LOAD  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_rd_rem;
  logic [BC_W-1:0]     r_burst;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_err;
  logic                r_abort_pend;
  logic                r_aborted;

  logic                w_abort;
  logic                w_abort_done;
  logic                w_fifo_clr;
  logic                w_fifo_wr_en;
  logic [DATA_W-1:0]   w_fifo_din;
  logic                w_fifo_rd_en;
  logic                w_rd_req;
  logic                w_wr_req;
  logic                w_flag_err;

`ifdef DMA_CTRL_ABORT_EN
  // A pending abort is remembered until the outstanding request is acked.
  assign w_abort = abort | r_abort_pend;
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state and strobe decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    w_fifo_clr   = 1'b0;
    w_fifo_wr_en = 1'b0;
    w_fifo_din   = '0;
    w_fifo_rd_en = 1'b0;
    w_rd_req     = 1'b0;
    w_wr_req     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_fifo_clr = 1'b1;
          w_next     = (cfg_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        w_rd_req = 1'b1;
        if (rd_ack) begin
          w_fifo_wr_en = 1'b1;
          w_fifo_din   = rd_data;
          // Burst ends on the word that fills it or on the last word overall.
          if (w_abort)
            w_next = S_DONE;
          else if ((r_burst + BC_W'(1)) == BURST_MAX || r_rd_rem == LEN_W'(1))
            w_next = S_POP;
        end
      end
      S_POP: begin
        w_fifo_rd_en = 1'b1;
        w_next       = w_abort ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        w_next = w_abort ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        w_wr_req = 1'b1;
        if (wr_ack) begin
          // r_burst still counts the word being acked this cycle.
          if (w_abort)
            w_next = S_DONE;
          else if (r_burst != BC_W'(1))
            w_next = S_POP;
          else if (r_rd_rem != '0)
            w_next = S_READ;
          else
            w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_flag_err   = (w_fifo_wr_en && fifo_full) || (w_fifo_rd_en && fifo_empty);
  assign w_abort_done = w_abort && (w_next == S_DONE) &&
                        (r_state != S_IDLE) && (r_state != S_DONE);

  // -------------------------------------------------------------------------
  // State, pointers, counters and write-data register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_rd_rem     <= '0;
      r_burst      <= '0;
      r_wr_data    <= '0;
      r_err        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src        <= cfg_src;
            r_dst        <= cfg_dst;
            r_rd_rem     <= cfg_len;
            r_burst      <= '0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_aborted    <= 1'b0;
          end
        end
        S_READ: begin
          if (rd_ack) begin
            r_src    <= r_src + ADDR_W'(1);
            r_rd_rem <= r_rd_rem - LEN_W'(1);
            r_burst  <= r_burst + BC_W'(1);
          end
          if (w_abort && !rd_ack)
            r_abort_pend <= 1'b1;
        end
        S_LOAD: begin
          r_wr_data <= fifo_dout;
        end
        S_WRITE: begin
          if (wr_ack) begin
            r_dst   <= r_dst + ADDR_W'(1);
            r_burst <= r_burst - BC_W'(1);
          end
          if (w_abort && !wr_ack)
            r_abort_pend <= 1'b1;
        end
        S_DONE: begin
          r_abort_pend <= 1'b0;
        end
        default: begin
        end
      endcase
      if (w_abort_done)
        r_aborted <= 1'b1;
      if (w_flag_err)
        r_err <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign rd_req     = w_rd_req;
  assign rd_addr    = r_src;
  assign wr_req     = w_wr_req;
  assign wr_addr    = r_dst;
  assign wr_data    = r_wr_data;
  assign fifo_clr   = w_fifo_clr;
  assign fifo_wr_en = w_fifo_wr_en;
  assign fifo_din   = w_fifo_din;
  assign fifo_rd_en = w_fifo_rd_en;

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_fifo_ctrl
//   Directed bench for dma_fifo_ctrl. Includes a behavioural 16-deep FIFO with
//   registered read data, read/write responders with programmable ack delays,
//   and a negedge monitor that logs transactions. Source memory returns
//   {16'hC0DE, addr[15:0]} (or 32'hDEADBEEF in the single-word test).
//   The abort scenario is built only with DMA_CTRL_ABORT_EN.
// ---------------------------------------------------------------------------
module tb_dma_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        busy, done, err;
  logic        rd_req, rd_ack, wr_req, wr_ack;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  logic        fifo_clr, fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [31:0] fifo_din, fifo_dout;
`ifdef DMA_CTRL_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  always #5 clk = ~clk;

  dma_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err),
`ifdef DMA_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .fifo_clr(fifo_clr), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty)
  );

  // Behavioural FIFO
  logic [31:0] fmem [16];
  int          fcnt = 0;
  logic [3:0]  fwp = '0, frp = '0;
  assign fifo_full  = (fcnt == 16);
  assign fifo_empty = (fcnt == 0);
  always @(posedge clk) begin
    if (fifo_clr) begin
      fcnt <= 0; fwp <= '0; frp <= '0;
    end else begin
      if (fifo_wr_en && fcnt < 16) begin fmem[fwp] <= fifo_din; fwp <= fwp + 4'd1; end
      if (fifo_rd_en && fcnt > 0)  begin fifo_dout <= fmem[frp]; frp <= frp + 4'd1; end
      fcnt <= fcnt + ((fifo_wr_en && fcnt < 16) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
    end
  end

  // Responders: decide acks 1 time unit after each rising edge
  int rd_min = 0, rd_max = 0, wr_min = 0, wr_max = 0;
  int rd_dly = 0, wr_dly = 0;
  bit beef_mode = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    if (rd_req) begin
      if (rd_dly == 0) begin
        rd_ack  = 1'b1;
        rd_data = beef_mode ? 32'hDEADBEEF : mem_val(rd_addr);
        rd_dly  = $urandom_range(rd_max, rd_min);
      end else rd_dly--;
    end
    if (wr_req) begin
      if (wr_dly == 0) begin
        wr_ack = 1'b1;
        wr_dly = $urandom_range(wr_max, wr_min);
      end else wr_dly--;
    end
  end

  // Monitor (samples on falling edge)
  logic [31:0] rd_log[$], wa_log[$], wd_log[$];
  int burst_log[$];
  int n_rdreq, n_wrreq, n_clr, n_done, n_both, n_fwr, n_frd, max_occ, cur_burst;
  int n_unstable, n_bad_push;
  bit rd_pend, wr_pend;
  logic [31:0] prev_ra, prev_wa, prev_wd;

  task automatic clear_stats();
    rd_log.delete(); wa_log.delete(); wd_log.delete(); burst_log.delete();
    n_rdreq = 0; n_wrreq = 0; n_clr = 0; n_done = 0; n_both = 0;
    n_fwr = 0; n_frd = 0; max_occ = 0; cur_burst = 0;
    n_unstable = 0; n_bad_push = 0; rd_pend = 0; wr_pend = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_req) n_rdreq++;
      if (wr_req) n_wrreq++;
      if (fifo_clr) n_clr++;
      if (done) n_done++;
      if (fifo_wr_en && fifo_rd_en) n_both++;
      if (rd_req && rd_ack) begin
        rd_log.push_back(rd_addr);
        cur_burst++;
        if (!fifo_wr_en || fifo_din !== rd_data) n_bad_push++;
      end
      if (fifo_wr_en) n_fwr++;
      if (fifo_rd_en) begin
        n_frd++;
        if (cur_burst != 0) begin burst_log.push_back(cur_burst); cur_burst = 0; end
      end
      if (n_fwr - n_frd > max_occ) max_occ = n_fwr - n_frd;
      if (wr_req && wr_ack) begin wa_log.push_back(wr_addr); wd_log.push_back(wr_data); end
      if (rd_pend && rd_req && rd_addr !== prev_ra) n_unstable++;
      if (wr_pend && wr_req && (wr_addr !== prev_wa || wr_data !== prev_wd)) n_unstable++;
      rd_pend = rd_req && !rd_ack;
      wr_pend = wr_req && !wr_ack;
      prev_ra = rd_addr; prev_wa = wr_addr; prev_wd = wr_data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1; cfg_src = s; cfg_dst = d; cfg_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_timeout"}, busy, 1'b0);
  endtask

  task automatic chk_writes(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
    int bad = 0;
    chk({tag, "_nwrites"}, wa_log.size(), n);
    for (int i = 0; i < n && i < wa_log.size(); i++) begin
      if (wa_log[i] !== d + i) bad++;
      if (wd_log[i] !== mem_val(s + i)) bad++;
    end
    chk({tag, "_wr_content"}, bad, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    rd_ack = 1'b0; wr_ack = 1'b0; rd_data = '0;
`ifdef DMA_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_addrs", {rd_addr, wr_addr}, 64'h0);
    chk("rst_strobes", {fifo_clr, fifo_wr_en, fifo_rd_en}, 0);
    rst_n = 1'b1;

    // Single word
    clear_stats(); beef_mode = 1'b1;
    do_start(32'h100, 32'h200, 16'd1);
    wait_idle("len1", 50);
    chk("len1_nreads", rd_log.size(), 1);
    chk("len1_rd_addr", rd_log[0], 32'h100);
    chk("len1_fifo_wr", n_fwr, 1);
    chk("len1_fifo_rd", n_frd, 1);
    chk("len1_wr_addr", wa_log[0], 32'h200);
    chk("len1_wr_data", wd_log[0], 32'hDEADBEEF);
    chk("len1_done", n_done, 1);
    chk("len1_err", err, 0);
    beef_mode = 1'b0;

    // 40 words, zero-wait: bursts 16/16/8
    clear_stats();
    do_start(32'h0, 32'h1000, 16'd40);
    wait_idle("len40", 1000);
    chk("len40_nbursts", burst_log.size(), 3);
    chk("len40_bursts", {burst_log[0][15:0], burst_log[1][15:0], burst_log[2][15:0]}, {16'd16, 16'd16, 16'd8});
    chk_writes("len40", 32'h0, 32'h1000, 40);
    chk("len40_max_occ", max_occ, 16);
    chk("len40_done", n_done, 1);
    chk("len40_err", err, 0);
    chk("len40_no_both", n_both, 0);
    chk("len40_push_data", n_bad_push, 0);

    // Zero length
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; cfg_src = 32'h77; cfg_dst = 32'h88; cfg_len = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_done_T1", {done, busy}, 2'b11);
    @(posedge clk); #1;
    chk("len0_idle_T2", {done, busy}, 2'b00);
    chk("len0_no_req", {n_rdreq[15:0], n_wrreq[15:0]}, 0);
    chk("len0_no_fifo", {n_fwr[15:0], n_frd[15:0]}, 0);
    chk("len0_clr", n_clr, 1);

    // 20 words, random delays, start re-pulsed mid-transfer
    clear_stats();
    rd_min = 0; rd_max = 5; wr_min = 0; wr_max = 5;
    do_start(32'h40, 32'h2000, 16'd20);
    repeat (15) @(posedge clk);
    #1;
    start = 1'b1; cfg_src = 32'h9999; cfg_dst = 32'h5555; cfg_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("len20", 2000);
    chk_writes("len20", 32'h40, 32'h2000, 20);
    chk("len20_nreads", rd_log.size(), 20);
    chk("len20_stable", n_unstable, 0);
    chk("len20_one_clr", n_clr, 1);
    chk("len20_done", n_done, 1);
    rd_max = 0; wr_max = 0;

    // Reset during write of word 5
    clear_stats();
    wr_min = 3; wr_max = 3;
    do_start(32'h300, 32'h400, 16'd8);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
        @(posedge clk); #2;
        if (wr_req && !wr_ack && wa_log.size() == 4) hit = 1'b1;
      end
      chk("rstmid_reached", hit, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk("rstmid_ctrl", {busy, done, err, rd_req, wr_req}, 0);
    chk("rstmid_strobes", {fifo_clr, fifo_wr_en, fifo_rd_en}, 0);
    chk("rstmid_data", {wr_addr, wr_data}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_min = 0; wr_max = 0;
    chk("rstmid_no_done", n_done, 0);
    chk("rstmid_writes", wa_log.size(), 4);
    clear_stats();
    do_start(32'h500, 32'h600, 16'd3);
    wait_idle("after_rst", 200);
    chk_writes("after_rst", 32'h500, 32'h600, 3);
    chk("after_rst_done", n_done, 1);

`ifdef DMA_CTRL_ABORT_EN
    // Abort while word 18 is outstanding
    clear_stats();
    rd_min = 2; rd_max = 2;
    do_start(32'h0, 32'h1000, 16'd40);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        @(posedge clk); #2;
        if (rd_req && !rd_ack && rd_log.size() == 17) hit = 1'b1;
      end
      chk("abort_reached", hit, 1'b1);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_rd_held", rd_req, 1'b1);
    wait_idle("abort", 200);
    chk("abort_nreads", rd_log.size(), 18);
    chk("abort_nwrites", wa_log.size(), 16);
    chk("abort_done", n_done, 1);
    chk("abort_flag", aborted, 1'b1);
    rd_min = 0; rd_max = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
